// File: rtl/types_pkg.sv
// Shared scene/model/triangle types plus the streamer FSM encoding.
package types_pkg;

  localparam int MAX_OUTSTANDING_DEFAULT = 4;
  localparam int MODEL_ID_W = 8;
  localparam int TRI_IDX_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} streamer_state_t;

  typedef struct packed {
    logic [MODEL_ID_W-1:0] model_id;
    logic [31:0]           transform;
  } modelinstance_t;

  typedef struct packed {
    logic last;
  } modelinstance_meta_t;

  typedef struct packed {
    logic [MODEL_ID_W-1:0] model_index;
    logic [TRI_IDX_W-1:0]  triangle_index;
  } modelbuf_read_t;

  typedef struct packed {
    logic [31:0] vertices;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

  typedef struct packed {
    logic [31:0] transform;
    triangle_t   triangle;
  } triangle_tf_t;

  typedef struct packed {
    logic triangle_last;
    logic model_last;
  } triangle_tf_meta_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready stage; in_ready depends only on the skid register,
// so upstream ready is registered while throughput stays at one beat per cycle.
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     skid_data_p0;
  T     out_data_p1;
  logic skid_vld_p0;
  logic out_vld_p1;
  logic in_fire;
  logic load_out;

  assign in_ready  = !skid_vld_p0;
  assign in_fire   = in_valid && in_ready;
  assign load_out  = out_ready || !out_vld_p1;
  assign out_valid = out_vld_p1;
  assign out_data  = out_data_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_p1  <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (load_out) begin
      out_vld_p1  <= skid_vld_p0 || in_fire;
      skid_vld_p0 <= 1'b0;
    end else if (in_fire) begin
      skid_vld_p0 <= 1'b1;
    end
  end

  // stage p0 -> p1: the skid entry always drains before new input is taken
  always_ff @(posedge clk) begin
    if (load_out) out_data_p1 <= skid_vld_p0 ? skid_data_p0 : in_data;
    if (!load_out && in_fire) skid_data_p0 <= in_data;
  end

endmodule

// File: rtl/scene_triangle_streamer.sv
// Pairs each scene instance with its model's triangles, keeping several
// model-buffer reads in flight and discarding those issued past the last triangle.
module scene_triangle_streamer
  import types_pkg::*;
#(
  parameter int MAX_OUTSTANDING    = MAX_OUTSTANDING_DEFAULT,
  parameter int MAX_TRIANGLE_COUNT = 100
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                scene_in_valid,
  output logic                scene_in_ready,
  input  modelinstance_t      scene_in_data,
  input  modelinstance_meta_t scene_in_metadata,
  output logic                model_out_valid,
  input  logic                model_out_ready,
  output modelbuf_read_t      model_out_data,
  input  logic                model_in_valid,
  output logic                model_in_ready,
  input  triangle_t           model_in_data,
  input  triangle_meta_t      model_in_metadata,
  output logic                triangle_tf_out_valid,
  input  logic                triangle_tf_out_ready,
  output triangle_tf_t        triangle_tf_out_data,
  output triangle_tf_meta_t   triangle_tf_out_metadata,
  output logic                overrun_error
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]     OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TRI_IDX_W-1:0] IDX_END  = TRI_IDX_W'(MAX_TRIANGLE_COUNT);
  localparam logic [TRI_IDX_W-1:0] IDX_LAST = TRI_IDX_W'(MAX_TRIANGLE_COUNT - 1);

  typedef struct packed {
    triangle_tf_t      data;
    triangle_tf_meta_t meta;
  } beat_t;

  streamer_state_t     state;
  modelinstance_t      cur, pend;
  modelinstance_meta_t cur_meta, pend_meta;
  logic                pend_valid, last_seen;
  logic [OUT_W-1:0]    outstanding, outstanding_next;
  logic [TRI_IDX_W-1:0] req_idx, rsp_idx;
  logic scene_fire, req_fire, rsp_fire, fwd_valid, fwd_ready;
  logic at_limit, model_done, go_next, load_cur;
  beat_t fwd_beat, out_beat;

  assign scene_in_ready  = !pend_valid;
  assign scene_fire      = scene_in_valid && scene_in_ready;
  assign model_out_valid = (state == ISSUE) && (outstanding < OUT_MAX) &&
                           (req_idx < IDX_END) && !last_seen;
  assign model_out_data  = '{model_index: cur.model_id, triangle_index: req_idx};
  assign req_fire        = model_out_valid && model_out_ready;
  assign fwd_valid       = (state == ISSUE) && model_in_valid;
  assign model_in_ready  = (state == DRAIN) || ((state == ISSUE) && fwd_ready);
  assign rsp_fire        = model_in_valid && model_in_ready;
  assign at_limit        = (rsp_idx == IDX_LAST);
  assign model_done      = (state == ISSUE) && rsp_fire && (model_in_metadata.last || at_limit);

  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !rsp_fire)      outstanding_next = outstanding + OUT_W'(1);
    else if (rsp_fire && !req_fire) outstanding_next = outstanding - OUT_W'(1);
  end

  // A finished model hands over immediately when nothing is left in flight.
  assign go_next  = (model_done || (state == DRAIN)) && (outstanding_next == '0);
  assign load_cur = pend_valid && ((state == IDLE) || go_next);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      pend_valid    <= 1'b0;
      outstanding   <= '0;
      req_idx       <= '0;
      rsp_idx       <= '0;
      last_seen     <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (req_fire) req_idx <= req_idx + TRI_IDX_W'(1);
      if ((state == ISSUE) && rsp_fire) rsp_idx <= rsp_idx + TRI_IDX_W'(1);
      if (scene_fire) pend_valid <= 1'b1;
      if (model_done) begin
        last_seen <= 1'b1;
        if (at_limit && !model_in_metadata.last) overrun_error <= 1'b1;
      end
      case (state)
        IDLE:    state <= IDLE;
        ISSUE:   if (model_done) state <= go_next ? IDLE : DRAIN;
        DRAIN:   if (go_next) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (load_cur) begin
        state      <= ISSUE;
        pend_valid <= 1'b0;
        req_idx    <= '0;
        rsp_idx    <= '0;
        last_seen  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (scene_fire) begin
      pend      <= scene_in_data;
      pend_meta <= scene_in_metadata;
    end
    if (load_cur) begin
      cur      <= pend;
      cur_meta <= pend_meta;
    end
  end

  assign fwd_beat = '{
    data: '{transform: cur.transform, triangle: model_in_data},
    meta: '{triangle_last: model_in_metadata.last || at_limit, model_last: cur_meta.last}
  };

  // response -> registered output stage
  skid_buffer #(.T(beat_t)) u_out_stage (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (fwd_valid),
    .in_ready  (fwd_ready),
    .in_data   (fwd_beat),
    .out_valid (triangle_tf_out_valid),
    .out_ready (triangle_tf_out_ready),
    .out_data  (out_beat)
  );

  assign triangle_tf_out_data     = out_beat.data;
  assign triangle_tf_out_metadata = out_beat.meta;

endmodule

// File: tb/tb_scene_triangle_streamer.sv
// Directed bench: DUT 0 (4 outstanding, 4 triangles max) and DUT 1 (1 outstanding),
// each fed by a 2-cycle-latency model-buffer responder.
module tb_scene_triangle_streamer;
  import types_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic                scene_valid [2];
  logic                scene_ready [2];
  modelinstance_t      scene_data  [2];
  modelinstance_meta_t scene_meta  [2];
  logic                mo_valid [2];
  logic                mo_ready [2];
  modelbuf_read_t      mo_data  [2];
  logic                mi_valid [2];
  logic                mi_ready [2];
  triangle_t           mi_data  [2];
  triangle_meta_t      mi_meta  [2];
  logic                out_valid [2];
  logic                out_ready [2];
  triangle_tf_t        out_data  [2];
  triangle_tf_meta_t   out_meta  [2];
  logic                ovr [2];

  scene_triangle_streamer #(.MAX_OUTSTANDING(4), .MAX_TRIANGLE_COUNT(4)) dut_a (
    .clk(clk), .rstn(rstn),
    .scene_in_valid(scene_valid[0]), .scene_in_ready(scene_ready[0]),
    .scene_in_data(scene_data[0]), .scene_in_metadata(scene_meta[0]),
    .model_out_valid(mo_valid[0]), .model_out_ready(mo_ready[0]), .model_out_data(mo_data[0]),
    .model_in_valid(mi_valid[0]), .model_in_ready(mi_ready[0]),
    .model_in_data(mi_data[0]), .model_in_metadata(mi_meta[0]),
    .triangle_tf_out_valid(out_valid[0]), .triangle_tf_out_ready(out_ready[0]),
    .triangle_tf_out_data(out_data[0]), .triangle_tf_out_metadata(out_meta[0]),
    .overrun_error(ovr[0])
  );

  scene_triangle_streamer #(.MAX_OUTSTANDING(1), .MAX_TRIANGLE_COUNT(100)) dut_b (
    .clk(clk), .rstn(rstn),
    .scene_in_valid(scene_valid[1]), .scene_in_ready(scene_ready[1]),
    .scene_in_data(scene_data[1]), .scene_in_metadata(scene_meta[1]),
    .model_out_valid(mo_valid[1]), .model_out_ready(mo_ready[1]), .model_out_data(mo_data[1]),
    .model_in_valid(mi_valid[1]), .model_in_ready(mi_ready[1]),
    .model_in_data(mi_data[1]), .model_in_metadata(mi_meta[1]),
    .triangle_tf_out_valid(out_valid[1]), .triangle_tf_out_ready(out_ready[1]),
    .triangle_tf_out_data(out_data[1]), .triangle_tf_out_metadata(out_meta[1]),
    .overrun_error(ovr[1])
  );

  int cyc, checks, errors;
  logic [7:0]  rb_model [2][16];
  logic [7:0]  rb_idx   [2][16];
  int          rb_due   [2][16];
  int          rb_head [2], rb_tail [2];
  int          inflight [2], max_inflight [2], rq_n [2], rsp_n [2];
  logic [7:0]  rq_last [2];
  logic        scene_acc [2];
  logic [31:0] ob_tf  [2][16];
  logic [31:0] ob_tri [2][16];
  logic        ob_tl  [2][16];
  logic        ob_ml  [2][16];
  int          ob_n [2];
  logic        found;

  // Triangles per model id; unknown ids never assert last.
  function automatic int tri_cnt(input logic [7:0] m);
    case (m)
      8'd1: return 2;
      8'd2: return 1;
      8'd3: return 3;
      8'd4: return 4;
      8'd5: return 1;
      default: return 256;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic rf [2], pf [2], of [2], sf [2];
    int h;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rf[d] = mo_valid[d] && mo_ready[d];
      pf[d] = mi_valid[d] && mi_ready[d];
      of[d] = out_valid[d] && out_ready[d];
      sf[d] = scene_valid[d] && scene_ready[d];
      if (rf[d]) begin
        rb_model[d][rb_tail[d] % 16] = mo_data[d].model_index;
        rb_idx[d][rb_tail[d] % 16]   = mo_data[d].triangle_index;
        rb_due[d][rb_tail[d] % 16]   = cyc + 2;
        rb_tail[d]++;
        rq_n[d]++;
        rq_last[d] = mo_data[d].triangle_index;
      end
      if (of[d] && ob_n[d] < 16) begin
        ob_tf[d][ob_n[d]]  = out_data[d].transform;
        ob_tri[d][ob_n[d]] = out_data[d].triangle.vertices;
        ob_tl[d][ob_n[d]]  = out_meta[d].triangle_last;
        ob_ml[d][ob_n[d]]  = out_meta[d].model_last;
        ob_n[d]++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (sf[d]) begin
        scene_valid[d] = 1'b0;
        scene_acc[d]   = 1'b1;
      end
      if (pf[d]) begin
        rb_head[d]++;
        rsp_n[d]++;
      end
      inflight[d] = inflight[d] + int'(rf[d]) - int'(pf[d]);
      if (inflight[d] > max_inflight[d]) max_inflight[d] = inflight[d];
      h = rb_head[d] % 16;
      if (rb_head[d] != rb_tail[d] && rb_due[d][h] <= cyc) begin
        mi_valid[d] = 1'b1;
        mi_data[d]  = '{vertices: {8'hAB, rb_model[d][h], 8'h00, rb_idx[d][h]}};
        mi_meta[d]  = '{last: (int'(rb_idx[d][h]) == tri_cnt(rb_model[d][h]) - 1)};
      end else begin
        mi_valid[d] = 1'b0;
        mi_data[d]  = '0;
        mi_meta[d]  = '0;
      end
    end
  endtask

  task automatic send_scene(input int d, input logic [7:0] m, input logic [31:0] tf,
                            input logic ml);
    scene_data[d]  = '{model_id: m, transform: tf};
    scene_meta[d]  = '{last: ml};
    scene_valid[d] = 1'b1;
    scene_acc[d]   = 1'b0;
    for (int i = 0; i < 20 && !scene_acc[d]; i++) tick();
    chk($sformatf("scene_accept_d%0d_m%0d", d, m), scene_acc[d], 1'b1);
  endtask

  task automatic clear_obs(input int d);
    ob_n[d] = 0;
    rq_n[d] = 0;
    rsp_n[d] = 0;
    max_inflight[d] = inflight[d];
  endtask

  task automatic chk_beat(input int d, input int i, input logic [31:0] tf,
                          input logic [31:0] tri_v, input logic tl, input logic ml);
    chk($sformatf("d%0d_beat%0d_tf", d, i),  ob_tf[d][i],  tf);
    chk($sformatf("d%0d_beat%0d_tri", d, i), ob_tri[d][i], tri_v);
    chk($sformatf("d%0d_beat%0d_tlast", d, i), ob_tl[d][i], tl);
    chk($sformatf("d%0d_beat%0d_mlast", d, i), ob_ml[d][i], ml);
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      rb_head[d] = 0;
      rb_tail[d] = 0;
      inflight[d] = 0;
      mi_valid[d] = 1'b0;
      mi_data[d] = '0;
      mi_meta[d] = '0;
      scene_valid[d] = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      scene_data[d] = '0;
      scene_meta[d] = '0;
      mo_ready[d] = 1'b1;
      out_ready[d] = 1'b1;
      scene_acc[d] = 1'b0;
      rq_last[d] = '0;
      clear_obs(d);
    end
    reset_model();
    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_scene_ready", scene_ready[0], 1'b1);
    chk("rst_model_out_valid", mo_valid[0], 1'b0);
    chk("rst_model_in_ready", mi_ready[0], 1'b0);
    chk("rst_out_valid", out_valid[0], 1'b0);
    chk("rst_overrun", ovr[0], 1'b0);
    chk("rst_b_scene_ready", scene_ready[1], 1'b1);
    rstn = 1'b1;
    tick();

    // Single instance, 3-triangle model, one discarded read
    clear_obs(0);
    send_scene(0, 8'd3, 32'h1111_0001, 1'b1);
    chk("t1_latency_cycle1", mo_valid[0], 1'b0);
    tick();
    chk("t1_latency_cycle2", mo_valid[0], 1'b1);
    chk("t1_first_idx", mo_data[0].triangle_index, 8'd0);
    repeat (20) tick();
    chk("t1_req_count", rq_n[0], 4);
    chk("t1_req_last_idx", rq_last[0], 8'd3);
    chk("t1_rsp_count", rsp_n[0], 4);
    chk("t1_inflight_zero", inflight[0], 0);
    chk("t1_beats", ob_n[0], 3);
    chk_beat(0, 0, 32'h1111_0001, 32'hAB03_0000, 1'b0, 1'b1);
    chk_beat(0, 1, 32'h1111_0001, 32'hAB03_0001, 1'b0, 1'b1);
    chk_beat(0, 2, 32'h1111_0001, 32'hAB03_0002, 1'b1, 1'b1);

    // Two instances back-to-back, second held in the prefetch slot
    clear_obs(0);
    send_scene(0, 8'd1, 32'h2222_0001, 1'b0);
    send_scene(0, 8'd2, 32'h3333_0002, 1'b1);
    chk("t2_pend_full_ready", scene_ready[0], 1'b0);
    repeat (30) tick();
    chk("t2_beats", ob_n[0], 3);
    chk_beat(0, 0, 32'h2222_0001, 32'hAB01_0000, 1'b0, 1'b0);
    chk_beat(0, 1, 32'h2222_0001, 32'hAB01_0001, 1'b1, 1'b0);
    chk_beat(0, 2, 32'h3333_0002, 32'hAB02_0000, 1'b1, 1'b1);
    chk("t2_ready_after", scene_ready[0], 1'b1);

    // Output stalled 5 cycles mid-model
    clear_obs(0);
    send_scene(0, 8'd4, 32'h6666_0004, 1'b1);
    repeat (4) tick();
    out_ready[0] = 1'b0;
    repeat (5) tick();
    out_ready[0] = 1'b1;
    repeat (20) tick();
    chk("t3_max_inflight_le4", max_inflight[0] <= 4, 1'b1);
    chk("t3_req_count", rq_n[0], 4);
    chk("t3_beats", ob_n[0], 4);
    for (int i = 0; i < 4; i++)
      chk_beat(0, i, 32'h6666_0004, 32'hAB04_0000 + 32'(i), (i == 3), 1'b1);
    chk("t3_no_overrun", ovr[0], 1'b0);

    // Model without last: overrun at 4 triangles, next instance still works
    clear_obs(0);
    send_scene(0, 8'd7, 32'h4444_0007, 1'b0);
    repeat (20) tick();
    chk("t4_beats", ob_n[0], 4);
    for (int i = 0; i < 4; i++)
      chk_beat(0, i, 32'h4444_0007, 32'hAB07_0000 + 32'(i), (i == 3), 1'b0);
    chk("t4_overrun_set", ovr[0], 1'b1);
    clear_obs(0);
    send_scene(0, 8'd5, 32'h5555_0005, 1'b1);
    repeat (15) tick();
    chk("t4_next_beats", ob_n[0], 1);
    chk_beat(0, 0, 32'h5555_0005, 32'hAB05_0000, 1'b1, 1'b1);
    chk("t4_overrun_sticky", ovr[0], 1'b1);

    // Single outstanding read: strict alternation, nothing discarded
    clear_obs(1);
    send_scene(1, 8'd5, 32'h9999_0005, 1'b1);
    repeat (15) tick();
    chk("t5_req_count", rq_n[1], 1);
    chk("t5_rsp_count", rsp_n[1], 1);
    chk("t5_max_inflight", max_inflight[1], 1);
    chk("t5_beats", ob_n[1], 1);
    chk_beat(1, 0, 32'h9999_0005, 32'hAB05_0000, 1'b1, 1'b1);
    chk("t5_idle", mo_valid[1], 1'b0);

    // Asynchronous reset while draining discarded reads
    clear_obs(0);
    send_scene(0, 8'd5, 32'h7777_0005, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = out_valid[0];
    end
    chk("t6_reached_drain", found, 1'b1);
    chk("t6_reads_in_flight", inflight[0] > 0, 1'b1);
    #2;
    rstn = 1'b0;
    reset_model();
    #1;
    chk("t6_scene_ready", scene_ready[0], 1'b1);
    chk("t6_model_out_valid", mo_valid[0], 1'b0);
    chk("t6_model_in_ready", mi_ready[0], 1'b0);
    chk("t6_out_valid", out_valid[0], 1'b0);
    chk("t6_overrun_cleared", ovr[0], 1'b0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    clear_obs(0);
    send_scene(0, 8'd3, 32'h8888_0003, 1'b1);
    repeat (20) tick();
    chk("t6_beats", ob_n[0], 3);
    chk_beat(0, 0, 32'h8888_0003, 32'hAB03_0000, 1'b0, 1'b1);
    chk_beat(0, 2, 32'h8888_0003, 32'hAB03_0002, 1'b1, 1'b1);
    chk("t6_inflight_zero", inflight[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scene_triangle_streamer.md
# scene_triangle_streamer

Successor to the single-request scene reader. It pairs every model instance from the scene buffer with that model's triangles from the model buffer and emits one `triangle_tf_t` beat per triangle. Generalisations: up to `MAX_OUTSTANDING` model-buffer reads in flight, a one-deep prefetch slot for the next instance, in-order discard of reads issued past a model's last triangle, a registered output stage, and an overrun guard. Sits between the scene buffer and the transform stage.

## Interface
- `MAX_OUTSTANDING`, 4: maximum model-buffer reads in flight, range 1..15.
- `MAX_TRIANGLE_COUNT`, 100: maximum triangles per model; triangle indices run 0..MAX_TRIANGLE_COUNT-1.
- `clk`  in  1  single clock; all logic on posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `scene_in_valid` / `scene_in_ready`  in / out  1 / 1  scene instance handshake.
- `scene_in_data`  in  `modelinstance_t`  instance: `model_id` and transform.
- `scene_in_metadata`  in  `modelinstance_meta_t`  marks the last instance of the scene.
- `model_out_valid` / `model_out_ready`  out / in  1 / 1  read-request handshake.
- `model_out_data`  out  `modelbuf_read_t`  `model_index` and `triangle_index`.
- `model_in_valid` / `model_in_ready`  in / out  1 / 1  triangle response handshake; responses arrive in request order.
- `model_in_data`  in  `triangle_t`  triangle.
- `model_in_metadata`  in  `triangle_meta_t`  `last` marks the model's final triangle.
- `triangle_tf_out_valid` / `triangle_tf_out_ready`  out / in  1 / 1  output handshake.
- `triangle_tf_out_data`  out  `triangle_tf_t`  transform plus triangle.
- `triangle_tf_out_metadata`  out  `triangle_tf_meta_t`  `triangle_last` and `model_last`.
- `overrun_error`  out  1  sticky; set when a model exceeds MAX_TRIANGLE_COUNT.

## Operation
- Instance storage: `cur` (active instance) and `pend` (prefetch slot).
  - `scene_in_ready = !pend_valid`.
  - A scene handshake loads `pend`.
  - `cur` loads from `pend` whenever the FSM enters ISSUE.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE when `pend_valid`: load `cur`, clear `pend_valid`, `req_idx=0`, `rsp_idx=0`.
  - ISSUE -> DRAIN on accepting the response with `last`, or with `rsp_idx==MAX_TRIANGLE_COUNT-1`, if in-flight reads remain after that accept.
  - ISSUE -> next state directly if no reads remain after that accept. Next state is ISSUE (reload from `pend`) when `pend_valid`, otherwise IDLE.
  - DRAIN -> next state (same rule) when the outstanding count reaches 0.
- Request gating: `model_out_valid = (state==ISSUE) && outstanding<MAX_OUTSTANDING && req_idx<MAX_TRIANGLE_COUNT && !last_seen`.
  - `model_index = cur.model_id`; `triangle_index = req_idx`.
  - `req_idx` increments on each request handshake.
- Outstanding counter, width `$clog2(MAX_OUTSTANDING+1)`:
  - +1 on a request handshake, -1 on a response handshake, unchanged when both occur in one cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Response path in ISSUE: each response is forwarded into the output stage. `model_in_ready` equals the output stage's input-ready.
- Response path in DRAIN: `model_in_ready=1`. Responses are consumed and not forwarded.
- Forwarded beat contents:
  - transform = `cur.transform`.
  - `triangle_last = model_in_metadata.last || (rsp_idx==MAX_TRIANGLE_COUNT-1)`.
  - `model_last` = `cur` instance meta.
- Overrun: if `rsp_idx==MAX_TRIANGLE_COUNT-1` and `last=0`, set `overrun_error` (sticky until reset) and force `triangle_last=1`.
- Data registers are not reset; only control registers are reset.

## Timing
- Reset values:
  - FSM in IDLE; `pend_valid=0`; outstanding=0; `req_idx=0`; `rsp_idx=0`; `last_seen=0`.
  - Outputs: `scene_in_ready=1`, `model_out_valid=0`, `model_in_ready=0` (skid empty but FSM idle), `triangle_tf_out_valid=0`, `overrun_error=0`.
- Reset mid-operation drops all state, including in-flight reads. The upstream model buffer must be reset together with this block.
- Latency:
  - Scene accept to first `model_out_valid`: 2 cycles (load `pend`, then enter ISSUE).
  - Back-to-back instances: 1 idle request cycle between the last triangle's accept (or drain completion) and the next instance's first request.
  - Response accept to `triangle_tf_out_valid`: 1 cycle (registered).
- Throughput: 1 triangle per cycle, sustained when MAX_OUTSTANDING is at least the model-buffer read latency.
- Handshake rules:
  - Once valid is asserted, it and its data stay stable until ready.
  - `model_out_valid` may deassert only through an accept, or through `last_seen`/overrun on a response.
- Simultaneous `last` accept and request handshake: the request counts toward outstanding and is discarded in DRAIN.
- MAX_OUTSTANDING=1 reproduces strict request/response alternation with no discard.

## Structure
- `types_pkg` gains `localparam MAX_OUTSTANDING_DEFAULT` and `typedef enum logic [1:0] streamer_state_t {IDLE, ISSUE, DRAIN}`. The existing instance, triangle and modelbuf types are reused unchanged.
- Sub-module `skid_buffer #(type T)`: two-entry registered valid/ready stage carrying `{triangle_tf_t, triangle_tf_meta_t}`. It gives full throughput with registered ready.

## Test plan
- Single instance, model of 3 triangles, model-buffer read latency 2 cycles, output always ready:
  - Requests go out for indices 0..3.
  - 3 beats are emitted, with `triangle_last` on the third and `model_last` equal to the instance meta.
  - The 4th response is discarded and outstanding returns to 0.
- Two instances queued back-to-back (model_id 1 with 2 triangles, model_id 2 with 1 triangle):
  - The second instance is held in `pend` and `scene_in_ready=0` while the first is active.
  - Output is 3 beats with correct transforms; the second beat and the third beat both carry `triangle_last`.
- Output stalls (ready low for 5 cycles mid-model, MAX_OUTSTANDING=4):
  - No more than 4 requests are in flight.
  - No beat is lost or duplicated; order is 0,1,2,...
- Overrun with MAX_TRIANGLE_COUNT=4 and a model whose responses never set `last`:
  - Exactly 4 beats are emitted; the 4th has `triangle_last=1`.
  - `overrun_error` rises and stays high; the next instance proceeds normally.
- MAX_OUTSTANDING=1 with a 1-triangle model: one request, one beat, no discard.
- Reset asserted during DRAIN: all outputs return to their reset values immediately (asynchronously); after release the block accepts a new instance and streams it correctly.
